conv_mac_pipe: RTL and testbench

Streaming multi-channel convolution MAC. It multiplies a KERNEL_SIZE input window by signed sign-magnitude kernel weights and accumulates the result over CHANNELS consecutive input beats, starting from a signed bias. It then applies a run-time-selectable activation with saturation and presents one feature pixel per CHANNELS beats over a valid/ready output. It sits between the window line-buffer and the feature-map writer in the CNN datapath, and replaces the single-channel, fixed-activation, no-backpressure convolve stage.

---
 rtl/cnn_pkg.sv | 33 +++
 rtl/conv_act_sat.sv | 53 +++++
 rtl/conv_mac_pipe.sv | 137 +++++++++++++
 tb/tb_conv_mac_pipe.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// Shared CNN datapath types: activation selector, sign-magnitude kernel word,
// and width helpers for the convolution MAC.
package cnn_pkg;

    typedef enum logic [1:0] {
        RELU   = 2'd0,
        SIGNUM = 2'd1,
        ABS    = 2'd2,
        PASS   = 2'd3
    } act_mode_e;

    localparam int unsigned KDATA_WIDTH_DEF = 8;

    // Sign bit plus fractional magnitude; sign set means the tap subtracts.
    typedef struct packed {
        logic                       sign;
        logic [KDATA_WIDTH_DEF-2:0] mag;
    } kernel_t;

    function automatic int unsigned prod_width(input int unsigned data_w,
                                               input int unsigned kdata_w);
        return data_w + kdata_w - 1;
    endfunction

    function automatic int unsigned acc_width(input int unsigned data_w,
                                              input int unsigned kdata_w,
                                              input int unsigned taps,
                                              input int unsigned channels,
                                              input int unsigned bias_w);
        return data_w + kdata_w + $clog2(taps * channels) + bias_w - data_w + 1;
    endfunction

endpackage

// File: rtl/conv_act_sat.sv
// Combinational activation: drops the fixed-point fraction, applies the
// selected activation and flags saturation to the pixel range.
module conv_act_sat
    import cnn_pkg::*;
#(
    parameter int unsigned ACC_W      = 23,
    parameter int unsigned FRAC_W     = 7,
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic signed [ACC_W-1:0]      value,
    input  act_mode_e                    act_mode,
    output logic        [DATA_WIDTH-1:0] act_data_c,
    output logic                         act_sat_c
);

    localparam logic signed [ACC_W-1:0] MAX_PIX = ACC_W'({DATA_WIDTH{1'b1}});

    logic signed [ACC_W-1:0] int_val;
    logic signed [ACC_W-1:0] mag;
    logic                    neg;

    always_comb begin
        int_val    = value >>> FRAC_W;
        neg        = int_val[ACC_W-1];
        mag        = neg ? -int_val : int_val;
        act_data_c = '0;
        act_sat_c  = 1'b0;
        case (act_mode)
            RELU: begin
                if (neg) begin
                    act_data_c = '0;
                end else if (int_val > MAX_PIX) begin
                    act_data_c = '1;
                    act_sat_c  = 1'b1;
                end else begin
                    act_data_c = int_val[DATA_WIDTH-1:0];
                end
            end
            SIGNUM: act_data_c = neg ? '0 : '1;
            ABS: begin
                if (mag > MAX_PIX) begin
                    act_data_c = '1;
                    act_sat_c  = 1'b1;
                end else begin
                    act_data_c = mag[DATA_WIDTH-1:0];
                end
            end
            PASS: act_data_c = int_val[DATA_WIDTH-1:0];
            default: act_data_c = '0;
        endcase
    end

endmodule

// File: rtl/conv_mac_pipe.sv
// Streaming multi-channel convolution MAC: per-tap sign-magnitude products,
// accumulation over CHANNELS beats from a bias, activation, valid/ready output.
module conv_mac_pipe
    import cnn_pkg::*;
#(
    parameter int unsigned KERNEL_SIZE = 9,
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned KDATA_WIDTH = 8,
    parameter int unsigned CHANNELS    = 3,
    parameter int unsigned BIAS_WIDTH  = DATA_WIDTH + 1
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                flush,
    input  act_mode_e                           act_mode,
    input  logic signed [BIAS_WIDTH-1:0]        bias,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic [DATA_WIDTH*KERNEL_SIZE-1:0]   image,
    input  logic [KDATA_WIDTH*KERNEL_SIZE-1:0]  kernel,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [DATA_WIDTH-1:0]               out_data,
    output logic                                out_sat
);

    localparam int unsigned FRAC_W = KDATA_WIDTH - 1;
    localparam int unsigned PROD_W = prod_width(DATA_WIDTH, KDATA_WIDTH);
    localparam int unsigned ACC_W  = acc_width(DATA_WIDTH, KDATA_WIDTH, KERNEL_SIZE,
                                               CHANNELS, BIAS_WIDTH);
    localparam int unsigned CH_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam logic [CH_W-1:0] CH_LAST = CH_W'(CHANNELS - 1);

    logic                          stall;
    logic [CH_W-1:0]               ch;
    logic [PROD_W-1:0]             prod [KERNEL_SIZE];
    logic [KERNEL_SIZE-1:0]        neg;

    logic                          s1_valid;
    logic                          s1_first;
    logic                          s1_last;
    logic signed [BIAS_WIDTH-1:0]  s1_bias;
    logic [PROD_W-1:0]             s1_prod [KERNEL_SIZE];
    logic [KERNEL_SIZE-1:0]        s1_neg;

    logic signed [ACC_W-1:0]       acc;
    logic signed [ACC_W-1:0]       sum;
    logic signed [ACC_W-1:0]       base;
    logic signed [ACC_W-1:0]       total;
    logic [DATA_WIDTH-1:0]         act_data;
    logic                          act_sat;

    assign stall    = out_valid && !out_ready;
    assign in_ready = !stall;

    // Magnitude products per tap; the kernel sign travels alongside.
    always_comb begin
        for (int i = 0; i < KERNEL_SIZE; i++) begin
            prod[i] = PROD_W'(image[i*DATA_WIDTH +: DATA_WIDTH])
                    * PROD_W'(kernel[i*KDATA_WIDTH +: FRAC_W]);
            neg[i]  = kernel[i*KDATA_WIDTH + FRAC_W];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ch       <= '0;
            s1_valid <= 1'b0;
            s1_first <= 1'b0;
            s1_last  <= 1'b0;
            s1_bias  <= '0;
            s1_neg   <= '0;
            for (int i = 0; i < KERNEL_SIZE; i++) s1_prod[i] <= '0;
        end else if (flush) begin
            ch       <= '0;
            s1_valid <= 1'b0;
        end else if (!stall) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_prod  <= prod;
                s1_neg   <= neg;
                s1_first <= (ch == '0);
                s1_last  <= (ch == CH_LAST);
                if (ch == '0) s1_bias <= bias;
                ch <= (ch == CH_LAST) ? '0 : ch + CH_W'(1);
            end
        end
    end

    // Signed reduction of the registered products onto bias or running acc.
    always_comb begin
        sum = '0;
        for (int i = 0; i < KERNEL_SIZE; i++) begin
            sum = s1_neg[i] ? sum - ACC_W'(s1_prod[i]) : sum + ACC_W'(s1_prod[i]);
        end
        base  = s1_first ? (ACC_W'(s1_bias) <<< FRAC_W) : acc;
        total = base + sum;
    end

    conv_act_sat #(
        .ACC_W      (ACC_W),
        .FRAC_W     (FRAC_W),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_act (
        .value      (total),
        .act_mode   (act_mode),
        .act_data_c (act_data),
        .act_sat_c  (act_sat)
    );

    // Output register may be consumed and reloaded in the same cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sat   <= 1'b0;
        end else if (flush) begin
            acc       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sat   <= 1'b0;
        end else begin
            if (out_valid && out_ready) out_valid <= 1'b0;
            if (s1_valid && !stall) begin
                if (s1_last) begin
                    out_valid <= 1'b1;
                    out_data  <= act_data;
                    out_sat   <= act_sat;
                end else begin
                    acc <= total;
                end
            end
        end
    end

endmodule

// File: tb/tb_conv_mac_pipe.sv
// Scoreboard bench for conv_mac_pipe: a behavioural model queues expected
// pixels as beats are accepted; a monitor pops them on each output handshake.
module tb_conv_mac_pipe;
    import cnn_pkg::*;

    localparam int unsigned KS = 9;
    localparam int unsigned DW = 8;
    localparam int unsigned KW = 8;
    localparam int unsigned CH = 3;
    localparam int unsigned BW = DW + 1;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  flush;
    act_mode_e             act_mode;
    logic signed [BW-1:0]  bias;
    logic                  in_valid;
    logic                  in_ready;
    logic [DW*KS-1:0]      image;
    logic [KW*KS-1:0]      kernel;
    logic                  out_valid;
    logic                  out_ready;
    logic [DW-1:0]         out_data;
    logic                  out_sat;

    conv_mac_pipe #(
        .KERNEL_SIZE (KS),
        .DATA_WIDTH  (DW),
        .KDATA_WIDTH (KW),
        .CHANNELS    (CH),
        .BIAS_WIDTH  (BW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .act_mode  (act_mode),
        .bias      (bias),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .image     (image),
        .kernel    (kernel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sat   (out_sat)
    );

    always #5 clk = ~clk;

    int            n_vec = 0;
    int            n_err = 0;
    logic [DW:0]   exp_q [$];
    int            m_ch;
    longint        m_acc;
    logic [DW-1:0] img_a [KS];
    kernel_t       kern_a [KS];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Returns {sat, data} for an accumulated fixed-point value.
    function automatic logic [DW:0] model_act(input longint a, input act_mode_e m);
        longint iv;
        longint mx;
        longint mg;
        iv = a >>> (KW - 1);
        mx = (longint'(1) << DW) - 1;
        mg = (iv < 0) ? -iv : iv;
        case (m)
            RELU: begin
                if (iv < 0) return '0;
                if (iv > mx) return {1'b1, {DW{1'b1}}};
                return {1'b0, DW'(iv)};
            end
            SIGNUM: return (iv < 0) ? '0 : {1'b0, {DW{1'b1}}};
            ABS: begin
                if (mg > mx) return {1'b1, {DW{1'b1}}};
                return {1'b0, DW'(mg)};
            end
            default: return {1'b0, DW'(iv)};
        endcase
    endfunction

    task automatic fill(input logic [DW-1:0] iv, input logic [KW-1:0] kv);
        for (int i = 0; i < KS; i++) begin
            img_a[i]  = iv;
            kern_a[i] = kernel_t'(kv);
        end
    endtask

    task automatic fill_rand();
        for (int i = 0; i < KS; i++) begin
            img_a[i]  = DW'($urandom);
            kern_a[i] = kernel_t'(KW'($urandom));
        end
    endtask

    task automatic send_beat(input logic signed [BW-1:0] b);
        longint s;
        int     guard;
        s     = 0;
        guard = 0;
        for (int i = 0; i < KS; i++) begin
            image[i*DW +: DW]  = img_a[i];
            kernel[i*KW +: KW] = kern_a[i];
            if (kern_a[i].sign) s -= longint'(img_a[i]) * longint'(kern_a[i].mag);
            else                s += longint'(img_a[i]) * longint'(kern_a[i].mag);
        end
        bias     = b;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) begin
            check_val("in_ready_timeout", 0, 1);
        end else begin
            if (m_ch == 0) m_acc = longint'(b) * (longint'(1) << (KW - 1)) + s;
            else           m_acc += s;
            if (m_ch == CH - 1) exp_q.push_back(model_act(m_acc, act_mode));
            m_ch = (m_ch + 1) % CH;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_pixel(input logic signed [BW-1:0] b);
        repeat (CH) send_beat(b);
    endtask

    // Mode changes only once the previous pixel has left stage 2.
    task automatic set_mode(input act_mode_e m);
        repeat (2) @(posedge clk);
        #1;
        act_mode = m;
    endtask

    task automatic drain(input string tag);
        int g;
        g = 0;
        while (exp_q.size() != 0 && g < 200) begin
            @(posedge clk);
            #1;
            g++;
        end
        check_val(tag, exp_q.size(), 0);
    endtask

    task automatic check_cleared(input string tag);
        check_val({tag, "_valid"}, 32'(out_valid), 0);
        check_val({tag, "_data"},  32'(out_data),  0);
        check_val({tag, "_sat"},   32'(out_sat),   0);
    endtask

    // Output monitor: handshake-driven scoreboard pop plus ready/stall relation.
    initial begin
        logic [DW:0] e;
        forever begin
            @(negedge clk);
            if (rst && out_valid) begin
                check_val("in_ready_stall", 32'(in_ready), 32'(out_ready));
                if (out_ready) begin
                    if (exp_q.size() == 0) begin
                        check_val("spurious_out", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check_val("out_data", 32'(out_data), 32'(e[DW-1:0]));
                        check_val("out_sat",  32'(out_sat),  32'(e[DW]));
                    end
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        rst       = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        act_mode  = RELU;
        bias      = '0;
        image     = '0;
        kernel    = '0;
        m_ch      = 0;
        m_acc     = 0;
        fill(8'd0, 8'h00);

        repeat (3) @(posedge clk);
        #1;
        check_cleared("reset");
        check_val("reset_in_ready", 32'(in_ready), 1);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Basic RELU with latency check: valid after the edge following the last accept.
        fill(8'd10, 8'h40);
        send_pixel('0);
        check_val("lat_early", 32'(out_valid), 0);
        @(posedge clk);
        #1;
        check_val("lat_valid", 32'(out_valid), 1);
        check_val("lat_data",  32'(out_data),  135);

        // Negative kernel across all activation modes.
        fill(8'd10, 8'hC0);
        for (int m = 0; m < 4; m++) begin
            set_mode(act_mode_e'(m));
            send_pixel('0);
        end

        // Saturation.
        fill(8'd255, 8'h7F);
        set_mode(RELU);
        send_pixel('0);
        set_mode(PASS);
        send_pixel('0);

        // Bias.
        fill(8'd10, 8'h40);
        set_mode(RELU);
        send_pixel(BW'(-100));
        send_pixel(BW'(127));

        // Random windows with per-beat random bias in each mode.
        for (int m = 0; m < 4; m++) begin
            set_mode(act_mode_e'(m));
            repeat (2 * CH) begin
                fill_rand();
                send_beat(BW'($urandom));
            end
        end
        drain("mode_drain");

        // Backpressure: 4 back-to-back pixels, output held off for 5 cycles.
        set_mode(ABS);
        fork
            begin
                repeat (4 * CH) begin
                    fill_rand();
                    send_beat(BW'($urandom));
                end
            end
            begin
                int g;
                g = 0;
                while (!out_valid && g < 100) begin
                    @(posedge clk);
                    #1;
                    g++;
                end
                if (g >= 100) check_val("bp_timeout", 0, 1);
                out_ready = 1'b0;
                repeat (5) begin
                    @(posedge clk);
                    #1;
                end
                out_ready = 1'b1;
            end
        join
        drain("bp_drain");

        // Abort by flush; the beat offered during flush must be dropped.
        set_mode(RELU);
        fill(8'd10, 8'h40);
        send_beat('0);
        send_beat('0);
        fill(8'd200, 8'h7F);
        for (int i = 0; i < KS; i++) begin
            image[i*DW +: DW]  = img_a[i];
            kernel[i*KW +: KW] = kern_a[i];
        end
        flush    = 1'b1;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        m_ch     = 0;
        check_cleared("flush");
        fill(8'd10, 8'h40);
        send_pixel('0);
        drain("flush_drain");

        // Abort by asynchronous reset mid-pixel.
        send_beat('0);
        send_beat('0);
        rst = 1'b0;
        #1;
        check_cleared("rst_abort");
        check_val("rst_in_ready", 32'(in_ready), 1);
        @(posedge clk);
        #1;
        rst  = 1'b1;
        m_ch = 0;
        send_pixel('0);
        drain("final_drain");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
